// File: rtl/sdio_slot_mux_if.sv
// Wishbone control port of the SDIO slot multiplexer (single 32-bit register).
interface sdio_slot_mux_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_data
    );
endinterface

// File: rtl/sdio_slot_mux.sv
// Steers one SDIO controller onto one of NSLOT card sockets, switching only
// after a bus-idle guard period, and debounces per-slot card-detect lines.
module sdio_slot_mux #(
    parameter int unsigned NSLOT      = 2,
    parameter int unsigned LGDEBOUNCE = 16,
    parameter int unsigned GUARD      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    sdio_slot_mux_if.slave        wb,
    input  logic [7:0]            i_sdclk,
    input  logic                  i_cmd_en,
    input  logic                  i_pp_cmd,
    input  logic [1:0]            i_cmd_data,
    input  logic                  i_data_en,
    input  logic                  i_pp_data,
    input  logic [31:0]           i_tx_data,
    output logic [1:0]            o_cmd_strb,
    output logic [1:0]            o_cmd_data,
    output logic                  o_card_busy,
    output logic [1:0]            o_rx_strb,
    output logic [15:0]           o_rx_data,
    output logic                  o_card_detect,
    output logic                  o_int,
    output logic [8*NSLOT-1:0]    o_slot_sdclk,
    output logic [NSLOT-1:0]      o_slot_cmd_en,
    output logic [NSLOT-1:0]      o_slot_data_en,
    output logic                  o_slot_pp_cmd,
    output logic                  o_slot_pp_data,
    output logic [1:0]            o_slot_cmd_data,
    output logic [31:0]           o_slot_tx_data,
    input  logic [2*NSLOT-1:0]    i_slot_cmd_strb,
    input  logic [2*NSLOT-1:0]    i_slot_cmd_data,
    input  logic [NSLOT-1:0]      i_slot_busy,
    input  logic [2*NSLOT-1:0]    i_slot_rx_strb,
    input  logic [16*NSLOT-1:0]   i_slot_rx_data,
    input  logic [NSLOT-1:0]      i_slot_detect
);

    localparam int unsigned CW = ($clog2(GUARD + 1) > 1) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWITCH} state_t;

    state_t                r_state;
    logic [2:0]            r_active;
    logic [2:0]            r_target;
    logic [CW-1:0]         r_idle_cnt;
    logic [NSLOT-1:0]      r_present;
    logic [NSLOT-1:0]      r_chg;
    logic [NSLOT-1:0]      r_ien;
    logic [NSLOT-1:0]      r_sync1;
    logic [NSLOT-1:0]      r_sync2;
    logic [LGDEBOUNCE-1:0] r_db_cnt [NSLOT];
    logic                  r_ack;
    logic                  r_int;
    logic [31:0]           r_rdata;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_blank;
    logic                  w_busy_act;
    logic                  w_bus_idle;
    logic [NSLOT-1:0]      w_sat;
    logic [NSLOT-1:0]      w_clr;
    logic [31:0]           w_reg;
    logic                  w_unused;

    assign w_req    = wb.i_wb_cyc & wb.i_wb_stb;
    assign w_wr     = w_req & wb.i_wb_we;
    assign w_blank  = (r_state == S_SWITCH);
    assign w_clr    = (w_wr && wb.i_wb_sel[2]) ? wb.i_wb_data[16 +: NSLOT] : '0;
    assign w_unused = ^{wb.i_wb_sel[1], wb.i_wb_data};

    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_ack   = r_ack;
    assign wb.o_wb_data  = r_rdata;
    assign o_int         = r_int;

    assign o_slot_pp_cmd   = i_pp_cmd;
    assign o_slot_pp_data  = i_pp_data;
    assign o_slot_cmd_data = i_cmd_data;
    assign o_slot_tx_data  = i_tx_data;

    assign w_reg = {8'(r_ien), 8'(r_chg), 8'(r_present), 1'b0, r_target,
                    (r_state != S_IDLE), r_active};

    // Forward/return steering on the registered active slot; blanked during SWITCH
    always_comb begin
        o_slot_sdclk   = '0;
        o_slot_cmd_en  = '0;
        o_slot_data_en = '0;
        o_cmd_strb     = '0;
        o_cmd_data     = '0;
        o_card_busy    = 1'b0;
        o_rx_strb      = '0;
        o_rx_data      = '0;
        o_card_detect  = 1'b0;
        w_busy_act     = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            if (r_active == 3'(k)) begin
                w_busy_act    = i_slot_busy[k];
                o_card_detect = r_present[k];
                if (!w_blank) begin
                    o_slot_sdclk[8*k +: 8] = i_sdclk;
                    o_slot_cmd_en[k]       = i_cmd_en;
                    o_slot_data_en[k]      = i_data_en;
                    o_cmd_strb             = i_slot_cmd_strb[2*k +: 2];
                    o_cmd_data             = i_slot_cmd_data[2*k +: 2];
                    o_card_busy            = i_slot_busy[k];
                    o_rx_strb              = i_slot_rx_strb[2*k +: 2];
                    o_rx_data              = i_slot_rx_data[16*k +: 16];
                end
            end
        end
    end

    assign w_bus_idle = !i_cmd_en && !i_data_en && !w_busy_act;

    // Debounce counter saturation: the synchronized level has held long enough
    always_comb begin
        w_sat = '0;
        for (int k = 0; k < NSLOT; k++) begin
            w_sat[k] = (r_sync2[k] != r_present[k]) && (&r_db_cnt[k]);
        end
    end

    // Slot switch state machine with idle guard counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_active   <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_target != r_active) begin
                        r_state    <= S_DRAIN;
                        r_idle_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_target == r_active) begin
                        r_state <= S_IDLE;
                    end else if (!w_bus_idle) begin
                        r_idle_cnt <= '0;
                    end else if (32'(r_idle_cnt) + 32'd1 >= GUARD) begin
                        r_state <= S_SWITCH;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + CW'(1);
                    end
                end
                S_SWITCH: begin
                    r_active <= r_target;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Wishbone register access: one-cycle ack, registered read data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_target <= '0;
            r_ien    <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_rdata <= w_reg;
            end
            if (w_wr) begin
                if (wb.i_wb_sel[0] && (32'(wb.i_wb_data[2:0]) < NSLOT)) begin
                    r_target <= wb.i_wb_data[2:0];
                end
                if (wb.i_wb_sel[3]) begin
                    r_ien <= wb.i_wb_data[24 +: NSLOT];
                end
            end
        end
    end

    // Card-detect synchronizers, debounce counters, change flags and interrupt
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_present <= '0;
            r_chg     <= '0;
            r_int     <= 1'b0;
            for (int k = 0; k < NSLOT; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= i_slot_detect;
            r_sync2 <= r_sync1;
            for (int k = 0; k < NSLOT; k++) begin
                if (r_sync2[k] == r_present[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (w_sat[k]) begin
                    r_present[k] <= ~r_present[k];
                    r_db_cnt[k]  <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + LGDEBOUNCE'(1);
                end
            end
            // Hardware set wins over a same-cycle write-1-to-clear
            r_chg <= (r_chg & ~w_clr) | w_sat;
            r_int <= |(r_chg & r_ien);
        end
    end

endmodule

// File: tb/tb_sdio_slot_mux.sv
// Scoreboard bench for sdio_slot_mux: Wishbone replies are queued at issue
// time and checked by a separate monitor; steering and interrupts are
// checked directly against hand-computed values.
module tb_sdio_slot_mux;

    localparam int unsigned NSLOT      = 4;
    localparam int unsigned LGDEBOUNCE = 4;
    localparam int unsigned GUARD      = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           sdclk;
    logic                 cmd_en, pp_cmd, data_en, pp_data;
    logic [1:0]           cmd_data;
    logic [31:0]          tx_data;
    logic [1:0]           o_cmd_strb, o_cmd_data, o_rx_strb;
    logic                 o_card_busy, o_card_detect, o_int;
    logic [15:0]          o_rx_data;
    logic [8*NSLOT-1:0]   o_slot_sdclk;
    logic [NSLOT-1:0]     o_slot_cmd_en, o_slot_data_en;
    logic                 o_slot_pp_cmd, o_slot_pp_data;
    logic [1:0]           o_slot_cmd_data;
    logic [31:0]          o_slot_tx_data;
    logic [2*NSLOT-1:0]   s_cmd_strb, s_cmd_data, s_rx_strb;
    logic [NSLOT-1:0]     s_busy, s_detect;
    logic [16*NSLOT-1:0]  s_rx_data;

    sdio_slot_mux_if wb ();

    sdio_slot_mux #(.NSLOT(NSLOT), .LGDEBOUNCE(LGDEBOUNCE), .GUARD(GUARD)) dut (
        .i_clk(clk), .i_reset(rst), .wb(wb),
        .i_sdclk(sdclk), .i_cmd_en(cmd_en), .i_pp_cmd(pp_cmd), .i_cmd_data(cmd_data),
        .i_data_en(data_en), .i_pp_data(pp_data), .i_tx_data(tx_data),
        .o_cmd_strb(o_cmd_strb), .o_cmd_data(o_cmd_data), .o_card_busy(o_card_busy),
        .o_rx_strb(o_rx_strb), .o_rx_data(o_rx_data), .o_card_detect(o_card_detect),
        .o_int(o_int), .o_slot_sdclk(o_slot_sdclk), .o_slot_cmd_en(o_slot_cmd_en),
        .o_slot_data_en(o_slot_data_en), .o_slot_pp_cmd(o_slot_pp_cmd),
        .o_slot_pp_data(o_slot_pp_data), .o_slot_cmd_data(o_slot_cmd_data),
        .o_slot_tx_data(o_slot_tx_data), .i_slot_cmd_strb(s_cmd_strb),
        .i_slot_cmd_data(s_cmd_data), .i_slot_busy(s_busy), .i_slot_rx_strb(s_rx_strb),
        .i_slot_rx_data(s_rx_data), .i_slot_detect(s_detect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        int unsigned due;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Issue one Wishbone request and queue its expected reply
    task automatic wb_op(input logic we, input logic [3:0] sel, input logic [31:0] data,
                         input logic chk, input logic [31:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = we;
        wb.i_wb_sel  = sel;
        wb.i_wb_data = data;
        e.chk  = chk;
        e.data = exp;
        e.due  = cyc_cnt + 1;
        e.name = name;
        q.push_back(e);
        @(negedge clk);
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
        wb.i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] sel, input logic [31:0] data, input string name);
        wb_op(1'b1, sel, data, 1'b0, 32'h0, name);
    endtask

    task automatic wb_read(input logic [31:0] exp, input string name);
        wb_op(1'b0, 4'h0, 32'h0, 1'b1, exp, name);
    endtask

    // Monitor: every ack must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t m;
        if (!rst && wb.o_wb_ack) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with no request outstanding");
            end else begin
                m = q.pop_front();
                check({m.name, "_ack_cycle"}, cyc_cnt, m.due);
                check({m.name, "_stall"}, 32'(wb.o_wb_stall), 32'h0);
                if (m.chk) check(m.name, wb.o_wb_data, m.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        sdclk        = 8'h66;
        cmd_en       = 1'b0;
        data_en      = 1'b0;
        pp_cmd       = 1'b1;
        pp_data      = 1'b0;
        cmd_data     = 2'b10;
        tx_data      = 32'hCAFE_F00D;
        s_cmd_strb   = 8'b01_10_11_01;
        s_cmd_data   = 8'b11_10_01_00;
        s_rx_strb    = 8'b10_01_11_00;
        s_rx_data    = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
        s_busy       = '0;
        s_detect     = '0;
        wb.i_wb_cyc  = 1'b0;
        wb.i_wb_stb  = 1'b0;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_sel  = 4'h0;
        wb.i_wb_data = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(wb.o_wb_ack), 32'h0);
        check("reset_int", 32'(o_int), 32'h0);
        rst = 1'b0;
        check("reset_sdclk", o_slot_sdclk, 32'h0000_0066);
        check("reset_rx_data", 32'(o_rx_data), 32'h0000_A0A0);
        check("broadcast_tx", o_slot_tx_data, 32'hCAFE_F00D);
        wb_read(32'h0, "reset_reg");

        // Basic switch to slot 2: SWITCH cycle 9 edges after ack, new slot after 10
        wb_write(4'b0001, 32'd2, "wr_target2");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("pre_switch_sdclk", o_slot_sdclk, 32'h0000_0066);
        end
        @(negedge clk);
        check("switch_blank_sdclk", o_slot_sdclk, 32'h0);
        check("switch_blank_rx", 32'(o_rx_data), 32'h0);
        @(negedge clk);
        check("slot2_sdclk", o_slot_sdclk, 32'h0066_0000);
        check("slot2_rx_data", 32'(o_rx_data), 32'h0000_C2C2);
        check("slot2_cmd_data", 32'(o_cmd_data), 32'h2);
        @(negedge clk);
        cmd_en  = 1'b1;
        data_en = 1'b1;
        #1;
        check("slot2_cmd_en", 32'(o_slot_cmd_en), 32'h4);
        check("slot2_data_en", 32'(o_slot_data_en), 32'h4);
        cmd_en  = 1'b0;
        data_en = 1'b0;
        wb_read(32'h0000_0022, "after_switch");

        // Invalid target is ignored
        wb_write(4'b0001, 32'd5, "wr_target5");
        wb_read(32'h0000_0022, "invalid_target");
        repeat (15) @(negedge clk);
        check("invalid_no_switch", o_slot_sdclk, 32'h0066_0000);
        wb_read(32'h0000_0022, "invalid_target_late");

        // Abort during DRAIN: no SWITCH cycle may appear
        wb_write(4'b0001, 32'd1, "wr_target1");
        @(negedge clk);
        wb_read(32'h0000_001A, "drain_pending");
        wb_write(4'b0001, 32'd2, "wr_target2_abort");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_blank", o_slot_sdclk, 32'h0066_0000);
        end
        wb_read(32'h0000_0022, "after_abort");

        // Guard restart by cmd_en pulses every 5 cycles
        wb_write(4'b0001, 32'd3, "wr_target3");
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            cmd_en = 1'b1;
            @(negedge clk);
            cmd_en = 1'b0;
            if (p == 1) begin
                wb_read(32'h0000_003A, "pend_during_guard");
                @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
        end
        check("guard_held", o_slot_sdclk, 32'h0066_0000);
        @(negedge clk);
        cmd_en = 1'b1;
        @(negedge clk);
        cmd_en = 1'b0;
        check("guard_last_busy", o_slot_sdclk, 32'h0066_0000);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("guard_countdown", o_slot_sdclk, 32'h0066_0000);
        end
        @(negedge clk);
        check("guard_blank_sdclk", o_slot_sdclk, 32'h0);
        check("guard_blank_strb", 32'(o_cmd_strb), 32'h0);
        @(negedge clk);
        check("slot3_sdclk", o_slot_sdclk, 32'h6600_0000);
        check("slot3_rx_data", 32'(o_rx_data), 32'h0000_D3D3);
        wb_read(32'h0000_0033, "after_guard");

        // Debounce: glitch ignored, stable insert after 18 cycles
        wb_write(4'b1000, 32'h0200_0000, "wr_ien1");
        @(negedge clk);
        s_detect = 4'b0010;
        repeat (10) @(negedge clk);
        s_detect = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("glitch_int", 32'(o_int), 32'h0);
        end
        wb_read(32'h0200_0033, "glitch_no_change");
        @(negedge clk);
        s_detect = 4'b0010;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("debounce_wait_int", 32'(o_int), 32'h0);
        end
        @(negedge clk);
        check("insert_int", 32'(o_int), 32'h1);
        wb_read(32'h0202_0233, "insert_present");

        // Write-1-to-clear CHG[1] drops the interrupt one cycle later
        wb_write(4'b0100, 32'h0002_0000, "w1c_chg1");
        check("w1c_int_lag", 32'(o_int), 32'h1);
        @(negedge clk);
        check("w1c_int_clear", 32'(o_int), 32'h0);
        wb_read(32'h0200_0233, "after_w1c");

        // Removal with the enable cleared: CHG set, no interrupt
        wb_write(4'b1000, 32'h0, "wr_ien0");
        @(negedge clk);
        s_detect = 4'b0000;
        repeat (25) @(negedge clk);
        check("remove_no_int", 32'(o_int), 32'h0);
        wb_read(32'h0002_0033, "remove_chg");

        // Reset in the middle of a switch returns to slot 0 at once
        wb_write(4'b0001, 32'd0, "wr_target0");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_sdclk", o_slot_sdclk, 32'h0000_0066);
        wb_read(32'h0, "reset_mid_reg");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
